// File: rtl/round_pack_pkg.sv
// Shared rounding encodings, flag bit positions and NaN constants
// used by round_pack and the normalize stage.
package round_pack_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_W  = 5;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [22:0] CANON_NAN_FRAC = 23'h400000;

endpackage

// File: rtl/round_pack_decide.sv
// round_decide: increment and inexact decision for one operand.
// Unknown rounding modes fall back to round-to-nearest-even.
module round_decide
  import round_pack_pkg::*;
#(
  parameter int PARM_RM = 3,
  parameter logic [PARM_RM-1:0] PARM_RM_RNE = RM_RNE,
  parameter logic [PARM_RM-1:0] PARM_RM_RTZ = RM_RTZ,
  parameter logic [PARM_RM-1:0] PARM_RM_RDN = RM_RDN,
  parameter logic [PARM_RM-1:0] PARM_RM_RUP = RM_RUP,
  parameter logic [PARM_RM-1:0] PARM_RM_RMM = RM_RMM
) (
  input  logic [PARM_RM-1:0] rm_i,
  input  logic               sign_i,
  input  logic               guard_i,
  input  logic               round_i,
  input  logic               sticky_i,
  input  logic               lsb_i,
  output logic               inc_o,
  output logic               inexact_o
);

  logic rne_inc;

  always_comb begin
    inexact_o = guard_i | round_i | sticky_i;
    rne_inc   = guard_i & (round_i | sticky_i | lsb_i);
    inc_o     = rne_inc;
    unique case (1'b1)
      (rm_i == PARM_RM_RNE): inc_o = rne_inc;
      (rm_i == PARM_RM_RTZ): inc_o = 1'b0;
      (rm_i == PARM_RM_RDN): inc_o = inexact_o & sign_i;
      (rm_i == PARM_RM_RUP): inc_o = inexact_o & ~sign_i;
      (rm_i == PARM_RM_RMM): inc_o = guard_i;
      default:               inc_o = rne_inc;
    endcase
  end

endmodule

// File: rtl/round_pack.sv
// round_pack: round, pack and flag one IEEE-754 result per cycle.
// ROUND_PACK_SKID_EN adds a 1-entry skid buffer with registered Ready_o.
module round_pack
  import round_pack_pkg::*;
#(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_RM   = 3,
  parameter logic [PARM_RM-1:0] PARM_RM_RNE = RM_RNE,
  parameter logic [PARM_RM-1:0] PARM_RM_RTZ = RM_RTZ,
  parameter logic [PARM_RM-1:0] PARM_RM_RDN = RM_RDN,
  parameter logic [PARM_RM-1:0] PARM_RM_RUP = RM_RUP,
  parameter logic [PARM_RM-1:0] PARM_RM_RMM = RM_RMM
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          Valid_i,
  output logic                          Ready_o,
  input  logic [PARM_MANT:0]            Mant_i,
  input  logic [PARM_EXP-1:0]           Exp_i,
  input  logic                          Sign_i,
  input  logic [1:0]                    Mant_lower_i,
  input  logic                          Sticky_i,
  input  logic [PARM_RM-1:0]            Rounding_mode_i,
  input  logic                          Invalid_i,
  input  logic                          Overflow_i,
  input  logic                          Underflow_i,
  output logic                          Valid_o,
  input  logic                          Ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [FLAG_W-1:0]             Flags_o,
  input  logic                          Fflags_clr_i,
  output logic [FLAG_W-1:0]             Fflags_o
);

  localparam int W = PARM_EXP + PARM_MANT + 1;
  localparam logic [PARM_EXP-1:0] EXP_ONES = '1;
  localparam logic [PARM_EXP-1:0] EXP_ONE =
    {{(PARM_EXP-1){1'b0}}, 1'b1};
  localparam logic [PARM_EXP-1:0] EXP_MAXF =
    {{(PARM_EXP-1){1'b1}}, 1'b0};

  logic inc;
  logic inexact;

  round_decide #(
    .PARM_RM     (PARM_RM),
    .PARM_RM_RNE (PARM_RM_RNE),
    .PARM_RM_RTZ (PARM_RM_RTZ),
    .PARM_RM_RDN (PARM_RM_RDN),
    .PARM_RM_RUP (PARM_RM_RUP),
    .PARM_RM_RMM (PARM_RM_RMM)
  ) u_decide (
    .rm_i      (Rounding_mode_i),
    .sign_i    (Sign_i),
    .guard_i   (Mant_lower_i[1]),
    .round_i   (Mant_lower_i[0]),
    .sticky_i  (Sticky_i),
    .lsb_i     (Mant_i[0]),
    .inc_o     (inc),
    .inexact_o (inexact)
  );

  logic [PARM_MANT+1:0] rnd;
  logic                 carry;
  logic                 special;
  logic                 sat;
  logic                 near_max;
  logic                 rnd_of;
  logic                 of_flag;
  logic [PARM_EXP-1:0]  exp_r;
  logic [PARM_MANT-1:0] frac_r;
  logic [W-1:0]         res_in;
  logic [FLAG_W-1:0]    flg_in;

  always_comb begin
    rnd = {1'b0, Mant_i} + {{(PARM_MANT+1){1'b0}}, inc};
    carry = rnd[PARM_MANT+1];
    special = (Exp_i == EXP_ONES) | Invalid_i;
    sat = (Rounding_mode_i == PARM_RM_RTZ)
        | ((Rounding_mode_i == PARM_RM_RDN) & ~Sign_i)
        | ((Rounding_mode_i == PARM_RM_RUP) & Sign_i);
    // beyond max-finite before rounding: saturating modes clamp
    near_max = (Exp_i == EXP_MAXF) & (&Mant_i) & inexact;
    exp_r  = Exp_i;
    frac_r = rnd[PARM_MANT-1:0];
    if (carry) begin
      exp_r  = Exp_i + EXP_ONE;
      frac_r = '0;
    end else if ((Exp_i == '0) && rnd[PARM_MANT]) begin
      exp_r = EXP_ONE;
    end
    rnd_of = ~special
           & ((carry & (exp_r == EXP_ONES)) | (near_max & sat));
    if (rnd_of) begin
      exp_r  = sat ? EXP_MAXF : EXP_ONES;
      frac_r = sat ? '1 : '0;
    end
    if (special) begin
      exp_r  = Exp_i;
      frac_r = Mant_i[PARM_MANT-1:0];
    end
    res_in  = {Sign_i, exp_r, frac_r};
    of_flag = Overflow_i | rnd_of;
    flg_in  = '0;
    flg_in[FLAG_NV] = Invalid_i;
    flg_in[FLAG_DZ] = 1'b0;
    flg_in[FLAG_OF] = of_flag;
    flg_in[FLAG_UF] = Underflow_i & inexact;
    flg_in[FLAG_NX] = ~special & (inexact | of_flag);
  end

  logic              vld_q, vld_d;
  logic [W-1:0]      res_q, res_d;
  logic [FLAG_W-1:0] flg_q, flg_d;
  logic [FLAG_W-1:0] ffl_q, ffl_d;
  logic              in_x;
  logic              out_x;

  assign in_x  = Valid_i & Ready_o;
  assign out_x = vld_q & Ready_i;

`ifdef ROUND_PACK_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [W-1:0]      skid_res_q, skid_res_d;
  logic [FLAG_W-1:0] skid_flg_q, skid_flg_d;
  logic              out_free;

  assign Ready_o  = ~skid_v_q;
  assign out_free = ~vld_q | Ready_i;

  always_comb begin
    vld_d      = vld_q;
    res_d      = res_q;
    flg_d      = flg_q;
    skid_v_d   = skid_v_q;
    skid_res_d = skid_res_q;
    skid_flg_d = skid_flg_q;
    if (out_free) begin
      if (skid_v_q) begin
        vld_d    = 1'b1;
        res_d    = skid_res_q;
        flg_d    = skid_flg_q;
        skid_v_d = 1'b0;
      end else if (in_x) begin
        vld_d = 1'b1;
        res_d = res_in;
        flg_d = flg_in;
      end else begin
        vld_d = 1'b0;
      end
    end else if (in_x) begin
      skid_v_d   = 1'b1;
      skid_res_d = res_in;
      skid_flg_d = flg_in;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_v_q   <= 1'b0;
      skid_res_q <= '0;
      skid_flg_q <= '0;
    end else begin
      skid_v_q   <= skid_v_d;
      skid_res_q <= skid_res_d;
      skid_flg_q <= skid_flg_d;
    end
  end
`else
  assign Ready_o = ~vld_q | Ready_i;

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    flg_d = flg_q;
    if (in_x) begin
      vld_d = 1'b1;
      res_d = res_in;
      flg_d = flg_in;
    end else if (out_x) begin
      vld_d = 1'b0;
    end
  end
`endif

  // a clear coinciding with a transfer keeps only that transfer's flags
  always_comb begin
    ffl_d = ffl_q;
    if (Fflags_clr_i) ffl_d = out_x ? flg_q : '0;
    else if (out_x)   ffl_d = ffl_q | flg_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
      ffl_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      flg_q <= flg_d;
      ffl_q <= ffl_d;
    end
  end

  assign Valid_o  = vld_q;
  assign Result_o = res_q;
  assign Flags_o  = flg_q;
  assign Fflags_o = ffl_q;

endmodule

// File: tb/tb_round_pack.sv
// Directed testbench for round_pack (default or skid build).
module tb_round_pack;
  import round_pack_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        Valid_i = 1'b0;
  logic        Ready_o;
  logic [23:0] Mant_i = '0;
  logic [7:0]  Exp_i = '0;
  logic        Sign_i = 1'b0;
  logic [1:0]  Mant_lower_i = '0;
  logic        Sticky_i = 1'b0;
  logic [2:0]  Rounding_mode_i = '0;
  logic        Invalid_i = 1'b0;
  logic        Overflow_i = 1'b0;
  logic        Underflow_i = 1'b0;
  logic        Valid_o;
  logic        Ready_i = 1'b1;
  logic [31:0] Result_o;
  logic [4:0]  Flags_o;
  logic        Fflags_clr_i = 1'b0;
  logic [4:0]  Fflags_o;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0]  rm;
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [1:0]  lo;
    logic        st;
    logic        inv;
    logic        ovf;
    logic        unf;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  round_pack u_dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .Valid_i         (Valid_i),
    .Ready_o         (Ready_o),
    .Mant_i          (Mant_i),
    .Exp_i           (Exp_i),
    .Sign_i          (Sign_i),
    .Mant_lower_i    (Mant_lower_i),
    .Sticky_i        (Sticky_i),
    .Rounding_mode_i (Rounding_mode_i),
    .Invalid_i       (Invalid_i),
    .Overflow_i      (Overflow_i),
    .Underflow_i     (Underflow_i),
    .Valid_o         (Valid_o),
    .Ready_i         (Ready_i),
    .Result_o        (Result_o),
    .Flags_o         (Flags_o),
    .Fflags_clr_i    (Fflags_clr_i),
    .Fflags_o        (Fflags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input vec_t v);
    Rounding_mode_i = v.rm;
    Sign_i          = v.s;
    Exp_i           = v.e;
    Mant_i          = v.m;
    Mant_lower_i    = v.lo;
    Sticky_i        = v.st;
    Invalid_i       = v.inv;
    Overflow_i      = v.ovf;
    Underflow_i     = v.unf;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (Valid_o !== 1'b0 || Result_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b res=%h need 0/0",
               Valid_o, Result_o);
    end
    n_chk++;
    if (Flags_o !== 5'h0 || Fflags_o !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_flags: flags=%b fflags=%b need 0",
               Flags_o, Fflags_o);
    end
    n_chk++;
    if (Ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b need 1", Ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (Ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b need 1", Ready_o);
    end
  endtask

  task automatic test_round();
    vec_t tv [17];
    logic [4:0] exp_ff;
    tv = '{
      '{RM_RNE,1'b0,8'd127,24'h800000,2'b10,1'b0,1'b0,1'b0,1'b0,
        32'h3F800000,5'b00001},
      '{RM_RNE,1'b0,8'd127,24'hFFFFFF,2'b11,1'b0,1'b0,1'b0,1'b0,
        32'h40000000,5'b00001},
      '{RM_RUP,1'b0,8'd254,24'hFFFFFF,2'b10,1'b0,1'b0,1'b0,1'b0,
        32'h7F800000,5'b00101},
      '{RM_RTZ,1'b0,8'd254,24'hFFFFFF,2'b10,1'b0,1'b0,1'b0,1'b0,
        32'h7F7FFFFF,5'b00101},
      '{RM_RNE,1'b0,8'd0,24'h7FFFFF,2'b10,1'b0,1'b0,1'b0,1'b1,
        32'h00800000,5'b00011},
      '{RM_RDN,1'b1,8'd127,24'h800001,2'b00,1'b1,1'b0,1'b0,1'b0,
        32'hBF800002,5'b00001},
      '{RM_RMM,1'b0,8'd127,24'h800000,2'b10,1'b0,1'b0,1'b0,1'b0,
        32'h3F800001,5'b00001},
      '{RM_RNE,1'b0,8'd127,24'h800001,2'b00,1'b0,1'b0,1'b0,1'b0,
        32'h3F800001,5'b00000},
      '{RM_RNE,1'b0,8'd255,24'hC00000,2'b11,1'b1,1'b0,1'b0,1'b0,
        32'h7FC00000,5'b00000},
      '{RM_RNE,1'b0,8'd255,24'hC00000,2'b00,1'b0,1'b1,1'b0,1'b0,
        32'h7FC00000,5'b10000},
      '{RM_RNE,1'b1,8'd127,24'h800002,2'b10,1'b0,1'b0,1'b0,1'b0,
        32'hBF800002,5'b00001},
      '{3'b111,1'b0,8'd127,24'h800001,2'b10,1'b0,1'b0,1'b0,1'b0,
        32'h3F800002,5'b00001},
      '{RM_RDN,1'b0,8'd254,24'hFFFFFF,2'b01,1'b0,1'b0,1'b0,1'b0,
        32'h7F7FFFFF,5'b00101},
      '{RM_RTZ,1'b0,8'd127,24'h800000,2'b00,1'b0,1'b0,1'b1,1'b0,
        32'h3F800000,5'b00101},
      '{RM_RUP,1'b1,8'd254,24'hFFFFFF,2'b01,1'b0,1'b0,1'b0,1'b0,
        32'hFF7FFFFF,5'b00101},
      '{RM_RNE,1'b1,8'd254,24'hFFFFFF,2'b11,1'b0,1'b0,1'b0,1'b0,
        32'hFF800000,5'b00101},
      '{RM_RNE,1'b0,8'd0,24'h000010,2'b01,1'b0,1'b0,1'b0,1'b0,
        32'h00000010,5'b00001}
    };
    exp_ff = '0;
    Ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_i);
      drive(tv[i]);
      Valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      Valid_i = 1'b0;
      exp_ff = exp_ff | tv[i].flg;
      n_chk++;
      if (Valid_o !== 1'b1 || Result_o !== tv[i].res) begin
        n_fail++;
        $display("FAIL round_res[%0d]: valid=%b res=%h need 1/%h",
                 i, Valid_o, Result_o, tv[i].res);
      end
      n_chk++;
      if (Flags_o !== tv[i].flg) begin
        n_fail++;
        $display("FAIL round_flags[%0d]: got %b need %b",
                 i, Flags_o, tv[i].flg);
      end
    end
    @(posedge clk_i);
    #1;
    n_chk++;
    if (Fflags_o !== exp_ff) begin
      n_fail++;
      $display("FAIL fflags_accum: got %b need %b", Fflags_o, exp_ff);
    end
  endtask

  task automatic test_fflags_clr();
    vec_t v;
    v = '{RM_RNE,1'b0,8'd127,24'h800000,2'b10,1'b0,1'b0,1'b0,1'b0,
          32'h3F800000,5'b00001};
    Ready_i = 1'b1;
    @(negedge clk_i);
    drive(v);
    Valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    Valid_i = 1'b0;
    Fflags_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    Fflags_clr_i = 1'b0;
    n_chk++;
    if (Fflags_o !== 5'b00001) begin
      n_fail++;
      $display("FAIL clr_with_xfer: got %b need 00001", Fflags_o);
    end
    @(negedge clk_i);
    Fflags_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    Fflags_clr_i = 1'b0;
    n_chk++;
    if (Fflags_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL clr_alone: got %b need 00000", Fflags_o);
    end
  endtask

  task automatic test_back_to_back();
    vec_t tv [4];
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    logic in_x, out_x;
    tv = '{
      '{RM_RNE,1'b0,8'd127,24'h800001,2'b00,1'b0,1'b0,1'b0,1'b0,
        32'h3F800001,5'b00000},
      '{RM_RNE,1'b0,8'd127,24'h800002,2'b00,1'b0,1'b0,1'b0,1'b0,
        32'h3F800002,5'b00000},
      '{RM_RNE,1'b0,8'd127,24'h800003,2'b10,1'b0,1'b0,1'b0,1'b0,
        32'h3F800004,5'b00001},
      '{RM_RNE,1'b0,8'd127,24'h800005,2'b00,1'b0,1'b0,1'b0,1'b0,
        32'h3F800005,5'b00000}
    };
    while (out_idx < 4 && cyc < 30) begin
      @(negedge clk_i);
      Ready_i = (cyc >= 3);
      if (in_idx < 4) begin
        drive(tv[in_idx]);
        Valid_i = 1'b1;
      end else begin
        Valid_i = 1'b0;
      end
      #1;
      if (Valid_o === 1'b1) begin
        n_chk++;
        if (Result_o !== tv[out_idx].res ||
            Flags_o !== tv[out_idx].flg) begin
          n_fail++;
          $display("FAIL b2b_out[%0d] cyc %0d: %h/%b need %h/%b",
                   out_idx, cyc, Result_o, Flags_o,
                   tv[out_idx].res, tv[out_idx].flg);
        end
      end
`ifdef ROUND_PACK_SKID_EN
      if (cyc == 1) begin
        n_chk++;
        if (Ready_o !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_c1: got %b need 1", Ready_o);
        end
      end
`else
      if (cyc == 1) begin
        n_chk++;
        if (Ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_c1: got %b need 0", Ready_o);
        end
      end
`endif
      if (cyc == 2) begin
        n_chk++;
        if (Ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_c2: got %b need 0", Ready_o);
        end
      end
      in_x  = Valid_i & Ready_o;
      out_x = Valid_o & Ready_i;
      @(posedge clk_i);
      if (in_x) in_idx++;
      if (out_x) out_idx++;
      cyc++;
    end
    Valid_i = 1'b0;
    n_chk++;
    if (out_idx != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d need 4 (timeout)", out_idx);
    end
    @(negedge clk_i);
    n_chk++;
    if (Valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b need 0", Valid_o);
    end
  endtask

  task automatic test_reset_inflight();
    vec_t v;
    logic seen;
    v = '{RM_RNE,1'b0,8'd127,24'h800000,2'b10,1'b0,1'b0,1'b0,1'b0,
          32'h3F800000,5'b00001};
    Ready_i = 1'b0;
    @(negedge clk_i);
    drive(v);
    Valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    Valid_i = 1'b0;
    n_chk++;
    if (Valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_valid: got %b need 1", Valid_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_chk++;
    if (Valid_o !== 1'b0 || Result_o !== 32'h0 || Flags_o !== 5'h0) begin
      n_fail++;
      $display("FAIL rst_async: v=%b r=%h f=%b need 0",
               Valid_o, Result_o, Flags_o);
    end
    n_chk++;
    if (Fflags_o !== 5'h0 || Ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_fflags_ready: ff=%b rdy=%b need 0/1",
               Fflags_o, Ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    Ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (Valid_o !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_discard: result emitted after reset");
    end
  endtask

  initial begin
    test_reset();
    test_round();
    test_fflags_clr();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
